// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with DIRECT select and autonomous SCAN sweep (dwell_in+1 cycles per index).
// Latency: one cycle from sel_in/mode_in/en_in sampling to out; async active-low reset clears outputs immediately.
// Backpressure: none, outputs update every cycle; `define DECODER_SCAN_DIR_EN adds dir_in for down-scanning.
module decoder_scan_nto2n #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8,
    localparam int OUT_W  = 2**SEL_W
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               en_in,
    input  logic               mode_in,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic [DWELL_W-1:0] dwell_in,
`ifdef DECODER_SCAN_DIR_EN
    input  logic               dir_in,
`endif
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic [SEL_W-1:0]   IDX_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]   IDX_MAX   = {SEL_W{1'b1}};
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]   OUT_ONE   = {{(OUT_W-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [SEL_W-1:0]   scan_idx;
    logic [DWELL_W-1:0] dwell_cnt;

    logic [SEL_W-1:0]   start_idx;
    logic [SEL_W-1:0]   next_idx;
    logic               next_wrap;

    // Direction is only looked at when the index actually moves or the scan starts.
    always_comb begin
        start_idx = '0;
        next_idx  = scan_idx + IDX_ONE;
        next_wrap = (scan_idx == IDX_MAX);
`ifdef DECODER_SCAN_DIR_EN
        if (dir_in) begin
            start_idx = IDX_MAX;
            next_idx  = scan_idx - IDX_ONE;
            next_wrap = (scan_idx == '0);
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= ST_IDLE;
            scan_idx  <= '0;
            dwell_cnt <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            cur_sel   <= '0;
            wrap      <= 1'b0;
        end else if (!en_in) begin
            // Disable wins over any pending mode change or dwell expiry; cur_sel keeps its last value.
            state     <= ST_IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (!mode_in) begin
            state     <= ST_DIRECT;
            out       <= OUT_ONE << sel_in;
            out_valid <= 1'b1;
            cur_sel   <= sel_in;
            wrap      <= 1'b0;
        end else if (state != ST_SCAN) begin
            state     <= ST_SCAN;
            scan_idx  <= start_idx;
            dwell_cnt <= dwell_in;
            out       <= OUT_ONE << start_idx;
            out_valid <= 1'b1;
            cur_sel   <= start_idx;
            wrap      <= 1'b0;
        end else if (dwell_cnt == '0) begin
            scan_idx  <= next_idx;
            dwell_cnt <= dwell_in;
            out       <= OUT_ONE << next_idx;
            out_valid <= 1'b1;
            cur_sel   <= next_idx;
            wrap      <= next_wrap;
        end else begin
            dwell_cnt <= dwell_cnt - DWELL_ONE;
            wrap      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Directed bench for decoder_scan_nto2n (default 4-to-16 build): reset, DIRECT sweep, SCAN dwell/fast, priority, mode switch.
module tb_decoder_scan_nto2n;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        en_in;
    logic        mode_in;
    logic [3:0]  sel_in;
    logic [7:0]  dwell_in;
`ifdef DECODER_SCAN_DIR_EN
    logic        dir_in = 1'b0;
`endif
    logic [15:0] out;
    logic        out_valid;
    logic [3:0]  cur_sel;
    logic        wrap;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    decoder_scan_nto2n #(.SEL_W(4), .DWELL_W(8)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .en_in     (en_in),
        .mode_in   (mode_in),
        .sel_in    (sel_in),
        .dwell_in  (dwell_in),
`ifdef DECODER_SCAN_DIR_EN
        .dir_in    (dir_in),
`endif
        .out       (out),
        .out_valid (out_valid),
        .cur_sel   (cur_sel),
        .wrap      (wrap)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int wraps;
        logic [15:0] exp_out;

        rst_n_in = 1'b0;
        en_in    = 1'b0;
        mode_in  = 1'b0;
        sel_in   = '0;
        dwell_in = '0;
        #12;
        check("rst_out",   32'(out), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_sel",   32'(cur_sel), 32'h0);
        check("rst_wrap",  32'(wrap), 32'h0);

        rst_n_in = 1'b1;
        tick(); tick();
        check("idle_out",   32'(out), 32'h0);
        check("idle_valid", 32'(out_valid), 32'h0);

        // DIRECT sweep: each sel_in shows up one edge later
        en_in = 1'b1;
        for (int s = 0; s < 16; s++) begin
            sel_in = 4'(s);
            tick();
            exp_out = 16'h0001 << s;
            check("direct_out",   32'(out), 32'(exp_out));
            check("direct_sel",   32'(cur_sel), 32'(s));
            check("direct_valid", 32'(out_valid), 32'h1);
            check("direct_wrap",  32'(wrap), 32'h0);
        end

        // SCAN with dwell 2: three cycles per index, wrap 48 cycles after entry
        mode_in  = 1'b1;
        dwell_in = 8'd2;
        tick();
        check("scan_entry_out",  32'(out), 32'h1);
        check("scan_entry_sel",  32'(cur_sel), 32'h0);
        check("scan_entry_wrap", 32'(wrap), 32'h0);
        wraps = 0;
        for (int c = 1; c <= 48; c++) begin
            tick();
            exp_out = 16'h0001 << ((c / 3) % 16);
            check("scan_dwell_out",  32'(out), 32'(exp_out));
            check("scan_dwell_wrap", 32'(wrap), (c == 48) ? 32'h1 : 32'h0);
            if (wrap) wraps++;
        end
        check("scan_dwell_wrapcnt", 32'(wraps), 32'd1);

        // Disable for one cycle, then SCAN with dwell 0 restarts at index 0
        en_in = 1'b0;
        tick();
        check("dis_out", 32'(out), 32'h0);
        en_in    = 1'b1;
        dwell_in = 8'd0;
        tick();
        check("fast_entry_out", 32'(out), 32'h1);
        wraps = 0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            exp_out = 16'h0001 << (c % 16);
            check("fast_out",  32'(out), 32'(exp_out));
            check("fast_sel",  32'(cur_sel), 32'(c % 16));
            check("fast_wrap", 32'(wrap), (c % 16 == 0) ? 32'h1 : 32'h0);
            if (wrap) wraps++;
        end
        check("fast_wrapcnt", 32'(wraps), 32'd2);

        // Priority: en_in drops on the edge where dwell expires
        en_in = 1'b0;
        tick();
        en_in    = 1'b1;
        dwell_in = 8'd2;
        tick();
        check("prio_entry_out", 32'(out), 32'h1);
        tick(); tick();
        en_in = 1'b0;
        tick();
        check("prio_out",   32'(out), 32'h0);
        check("prio_valid", 32'(out_valid), 32'h0);
        check("prio_sel",   32'(cur_sel), 32'h0);
        check("prio_wrap",  32'(wrap), 32'h0);
        en_in = 1'b1;
        tick();
        check("reen_out", 32'(out), 32'h1);
        check("reen_sel", 32'(cur_sel), 32'h0);

        // Mode switch at index 7 (dwell 0, so that edge is also an expiry)
        en_in = 1'b0;
        tick();
        en_in    = 1'b1;
        dwell_in = 8'd0;
        tick();
        for (int c = 1; c <= 7; c++) tick();
        check("pre_switch_out", 32'(out), 32'h80);
        mode_in = 1'b0;
        sel_in  = 4'd3;
        tick();
        check("switch_out",   32'(out), 32'h8);
        check("switch_sel",   32'(cur_sel), 32'h3);
        check("switch_valid", 32'(out_valid), 32'h1);

        // DIRECT -> SCAN restarts at 0; reset asserted mid-scan at index 5
        mode_in = 1'b1;
        tick();
        check("d2s_out", 32'(out), 32'h1);
        for (int c = 1; c <= 5; c++) tick();
        check("pre_rst_out", 32'(out), 32'h20);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async_rst_out",   32'(out), 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_sel",   32'(cur_sel), 32'h0);
        en_in = 1'b0;
        #3;
        rst_n_in = 1'b1;
        tick(); tick(); tick();
        check("post_rst_out",   32'(out), 32'h0);
        check("post_rst_valid", 32'(out_valid), 32'h0);
        en_in = 1'b1;
        tick();
        check("post_rst_scan_out", 32'(out), 32'h1);
        check("post_rst_scan_sel", 32'(cur_sel), 32'h0);
        tick();
        check("post_rst_scan_step", 32'(out), 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
